// File: rtl/traffic_pkg.sv
// Shared light encodings, controller state enum and parameter arithmetic
// for the two-axis intersection controller.
package traffic_pkg;

  localparam logic [1:0] CAR_RED    = 2'b00;
  localparam logic [1:0] CAR_GREEN  = 2'b01;
  localparam logic [1:0] CAR_YELLOW = 2'b10;
  localparam logic [1:0] CAR_LEFT   = 2'b11;

  localparam logic [1:0] PED_RED    = 2'b00;
  localparam logic [1:0] PED_GREEN  = 2'b01;
  localparam logic [1:0] PED_BLINK  = 2'b10;

  typedef enum logic [2:0] {
    ST_A_GO   = 3'd0,
    ST_A_LEFT = 3'd1,
    ST_A_YEL  = 3'd2,
    ST_B_GO   = 3'd3,
    ST_B_LEFT = 3'd4,
    ST_B_YEL  = 3'd5,
    ST_FLASH  = 3'd6
  } state_e;

  function automatic int calc_total(input int t_pg, input int t_pb, input int t_clr,
                                    input int t_left, input int t_yel);
    return 2 * (t_pg + t_pb + t_clr + t_left + t_yel);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/traffic_ped_latch.sv
// One pedestrian push-button latch: set by a press, cleared when the crossing
// is served; a press landing on the clearing cycle wins and stays latched.
module traffic_ped_latch (
  input  logic clk,
  input  logic rst_n,
  input  logic i_set,
  input  logic i_clr,
  output logic o_q
);

  logic q_d;
  logic q_q;

  // NOTE: q_d gets its hold value first so every path assigns it and no latch is inferred.
  always_comb begin
    q_d = q_q;
    if (i_clr) q_d = 1'b0;
    if (i_set) q_d = 1'b1;
  end

  // NOTE: state flops use non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) q_q <= 1'b0;
    else        q_q <= q_d;
  end

  assign o_q = q_q;

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Two-axis intersection controller: one FSM and one phase timer drive both
// axes, with actuated pedestrian windows and a night flashing mode.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int T_PG         = 14,
  parameter int T_PB         = 6,
  parameter int T_CLR        = 2,
  parameter int T_LEFT       = 10,
  parameter int T_YEL        = 2,
  parameter int FLASH_HALF   = 4,
  parameter int PED_ACTUATED = 1,
  parameter int CW           = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    i_ped_req,
  input  logic          i_flash,
  output logic [1:0]    a_car,
  output logic [1:0]    b_car,
  output logic [1:0]    a_ped,
  output logic [1:0]    b_ped,
  output logic [1:0]    o_ped_wait,
  output logic [CW-1:0] o_cycle,
  output logic [2:0]    o_phase
);

  localparam int T_GO    = T_PG + T_PB + T_CLR;
  localparam int TOTAL   = calc_total(T_PG, T_PB, T_CLR, T_LEFT, T_YEL);
  localparam int CNT_MAX = max2(max2(T_GO, T_LEFT), max2(T_YEL, FLASH_HALF));
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [CW-1:0]    cyc_t;

  localparam cnt_t GO_C    = cnt_t'(T_GO);
  localparam cnt_t LEFT_C  = cnt_t'(T_LEFT);
  localparam cnt_t YEL_C   = cnt_t'(T_YEL);
  localparam cnt_t HALF_C  = cnt_t'(FLASH_HALF);
  localparam cnt_t BLINK_C = cnt_t'(T_PB + T_CLR);
  localparam cnt_t CLR_C   = cnt_t'(T_CLR);
  localparam cyc_t TOTAL_C = cyc_t'(TOTAL);

  if (TOTAL > (2 ** CW) - 1) begin : g_cw_too_narrow
    $error("traffic_phase_ctrl: cycle length %0d does not fit in CW=%0d bits", TOTAL, CW);
  end

  state_e     state_d, state_q;
  cnt_t       cnt_d, cnt_q;
  cyc_t       cycle_d, cycle_q;
  logic       served_d, served_q;
  logic       flash_yel_d, flash_yel_q;
  logic [1:0] a_car_d, a_car_q, b_car_d, b_car_q;
  logic [1:0] a_ped_d, a_ped_q, b_ped_d, b_ped_q;
  logic [1:0] wait_q;
  logic [1:0] ped_clr;
  logic       load;

  traffic_ped_latch u_latch_a (
    .clk   (clk),
    .rst_n (rst_n),
    .i_set (i_ped_req[0]),
    .i_clr (ped_clr[0]),
    .o_q   (wait_q[0])
  );

  traffic_ped_latch u_latch_b (
    .clk   (clk),
    .rst_n (rst_n),
    .i_set (i_ped_req[1]),
    .i_clr (ped_clr[1]),
    .o_q   (wait_q[1])
  );

  // Crossing light from the cycles remaining in a served GO phase.
  function automatic logic [1:0] ped_window(input cnt_t remaining);
    if (remaining > BLINK_C) return PED_GREEN;
    if (remaining > CLR_C)   return PED_BLINK;
    return PED_RED;
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q - cnt_t'(1);
    cycle_d     = (cycle_q == TOTAL_C) ? cyc_t'(1) : cycle_q + cyc_t'(1);
    served_d    = served_q;
    flash_yel_d = flash_yel_q;
    ped_clr     = 2'b00;
    load        = 1'b0;

    if (state_q == ST_FLASH) begin
      cycle_d = '0;
      if (cnt_q == cnt_t'(1)) begin
        if (i_flash) begin
          cnt_d       = HALF_C;
          flash_yel_d = !flash_yel_q;
        end else begin
          state_d = ST_A_GO;
          load    = 1'b1;
        end
      end
    end else if (cycle_q == '0) begin
      // First cycle out of reset starts a fresh A_GO.
      state_d = ST_A_GO;
      load    = 1'b1;
    end else if (cnt_q == cnt_t'(1)) begin
      load = 1'b1;
      unique case (state_q)
        ST_A_GO:   state_d = ST_A_LEFT;
        ST_A_LEFT: state_d = ST_A_YEL;
        ST_A_YEL:  state_d = i_flash ? ST_FLASH : ST_B_GO;
        ST_B_GO:   state_d = ST_B_LEFT;
        ST_B_LEFT: state_d = ST_B_YEL;
        ST_B_YEL:  state_d = i_flash ? ST_FLASH : ST_A_GO;
        default:   state_d = ST_A_GO;
      endcase
    end

    if (load) begin
      unique case (state_d)
        ST_A_GO: begin
          cnt_d      = GO_C;
          cycle_d    = cyc_t'(1);
          served_d   = (PED_ACTUATED == 0) || wait_q[1];
          ped_clr[1] = served_d;
        end
        ST_B_GO: begin
          cnt_d      = GO_C;
          served_d   = (PED_ACTUATED == 0) || wait_q[0];
          ped_clr[0] = served_d;
        end
        ST_A_LEFT, ST_B_LEFT: cnt_d = LEFT_C;
        ST_A_YEL,  ST_B_YEL:  cnt_d = YEL_C;
        ST_FLASH: begin
          cnt_d       = HALF_C;
          cycle_d     = '0;
          flash_yel_d = 1'b1;
        end
        default: cnt_d = GO_C;
      endcase
    end
  end

  // Lights are decoded from the next-state values so the registered outputs
  // line up with o_cycle and o_phase.
  always_comb begin
    a_car_d = CAR_RED;
    b_car_d = CAR_RED;
    a_ped_d = PED_RED;
    b_ped_d = PED_RED;
    unique case (state_d)
      ST_A_GO: begin
        a_car_d = CAR_GREEN;
        if (served_d) b_ped_d = ped_window(cnt_d);
      end
      ST_A_LEFT: a_car_d = CAR_LEFT;
      ST_A_YEL:  a_car_d = CAR_YELLOW;
      ST_B_GO: begin
        b_car_d = CAR_GREEN;
        if (served_d) a_ped_d = ped_window(cnt_d);
      end
      ST_B_LEFT: b_car_d = CAR_LEFT;
      ST_B_YEL:  b_car_d = CAR_YELLOW;
      ST_FLASH: begin
        a_car_d = flash_yel_d ? CAR_YELLOW : CAR_RED;
        b_car_d = flash_yel_d ? CAR_YELLOW : CAR_RED;
      end
      default: ;
    endcase
  end

  // NOTE: rst_n is sampled at the edge only; every flop is reset because outputs must read RED immediately.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_A_GO;
      cnt_q       <= '0;
      cycle_q     <= '0;
      served_q    <= 1'b0;
      flash_yel_q <= 1'b0;
      a_car_q     <= CAR_RED;
      b_car_q     <= CAR_RED;
      a_ped_q     <= PED_RED;
      b_ped_q     <= PED_RED;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cycle_q     <= cycle_d;
      served_q    <= served_d;
      flash_yel_q <= flash_yel_d;
      a_car_q     <= a_car_d;
      b_car_q     <= b_car_d;
      a_ped_q     <= a_ped_d;
      b_ped_q     <= b_ped_d;
    end
  end

  assign a_car      = a_car_q;
  assign b_car      = b_car_q;
  assign a_ped      = a_ped_q;
  assign b_ped      = b_ped_q;
  assign o_ped_wait = wait_q;
  assign o_cycle    = cycle_q;
  assign o_phase    = state_q;

endmodule
